// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the front end.
//   XLEN      : default architectural width of PC and branch targets
//   NOP_INSTR : bubble instruction (addi x0,x0,0)
//   fetch_action_t : one action per clock edge in the fetch stage, listed
//                    from highest to lowest priority
package cpu_pkg;

  localparam int          XLEN      = 64;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    RESET    = 3'd0,
    REDIRECT = 3'd1,
    FLUSH    = 3'd2,
    STALL    = 3'd3,
    ADVANCE  = 3'd4
  } fetch_action_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   load       : capture pc_in / instr_in as a real instruction
//   bubble     : replace contents with NOP, valid=0, keep the held pc
//   pc_in      : PC of the instruction being fetched
//   instr_in   : instruction being fetched
//   pc, instr, valid : registered IF/ID contents
// Priority: reset > bubble > load > hold.
module if_id_reg #(
  parameter int          XLEN      = cpu_pkg::XLEN,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            bubble,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     instr_in,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr,
  output logic            valid
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= '0;
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (bubble) begin
      // pc is left alone so the bubble still carries the last known PC
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (load) begin
      pc    <= pc_in;
      instr <= instr_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, IF/ID register, redirect and
// bubble performance counters, sticky misaligned-target flag.
//   clk, reset     : rising-edge clock, synchronous active-high reset
//   Switch_Branch  : taken-branch decision from EX (redirect)
//   Flush          : squash request for IF/ID
//   branch_target  : redirect address, used while Switch_Branch=1
//   stall          : freeze PC, IF/ID and counters
//   imem_addr      : current PC to instruction memory
//   imem_rdata     : instruction at imem_addr (same-cycle read)
//   if_id_pc/instr/valid : IF/ID register contents
//   misalign_err   : sticky, set by a redirect to a non-word-aligned target
//   redirect_cnt   : saturating count of redirects
//   bubble_cnt     : saturating count of bubbles inserted into IF/ID
module fetch_stage #(
  parameter int               XLEN      = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = cpu_pkg::NOP_INSTR,
  parameter int               CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Switch_Branch,
  input  logic             Flush,
  input  logic [XLEN-1:0]  branch_target,
  input  logic             stall,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [XLEN-1:0]  if_id_pc,
  output logic [31:0]      if_id_instr,
  output logic             if_id_valid,
  output logic             misalign_err,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  import cpu_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  fetch_action_t   action;
  logic [XLEN-1:0] pc;
  logic            ins_bubble;

  // Priority decode: a redirect outranks flush and stall because the branch
  // in EX is older than any hazard seen in ID.
  always_comb begin
    action = ADVANCE;
    if (reset)              action = RESET;
    else if (Switch_Branch) action = REDIRECT;
    else if (Flush)         action = FLUSH;
    else if (stall)         action = STALL;
  end

  assign ins_bubble = (action == REDIRECT) || (action == FLUSH);
  assign imem_addr  = pc;

  // PC register; the advance wraps modulo 2^XLEN with no flag
  always_ff @(posedge clk) begin
    case (action)
      RESET:    pc <= RESET_PC;
      REDIRECT: pc <= {branch_target[XLEN-1:2], 2'b00};
      ADVANCE:  pc <= pc + PC_STEP;
      default:  pc <= pc;
    endcase
  end

  // Counters and sticky error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_cnt <= '0;
      bubble_cnt   <= '0;
      misalign_err <= 1'b0;
    end else begin
      if (action == REDIRECT) begin
        redirect_cnt <= sat_inc(redirect_cnt);
        if (branch_target[1:0] != 2'b00) misalign_err <= 1'b1;
      end
      if (ins_bubble) bubble_cnt <= sat_inc(bubble_cnt);
    end
  end

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk      (clk),
    .reset    (reset),
    .load     (action == ADVANCE),
    .bubble   (ins_bubble),
    .pc_in    (pc),
    .instr_in (imem_rdata),
    .pc       (if_id_pc),
    .instr    (if_id_instr),
    .valid    (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sb = 1'b0;
  logic        fl = 1'b0;
  logic        st = 1'b0;
  logic [63:0] tgt = '0;

  logic [63:0] addr, ifpc, addr_s, ifpc_s;
  logic [31:0] rdata, rdata_s, ifinstr, ifinstr_s;
  logic        ifv, ifv_s, mis, mis_s;
  logic [31:0] rc, bc;
  logic [3:0]  rc_s, bc_s;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // Instruction memory: a recognisable word derived from the address
  function automatic logic [31:0] memf(input logic [63:0] a);
    return a[31:0] ^ 32'hA500_0000;
  endfunction

  assign rdata   = memf(addr);
  assign rdata_s = memf(addr_s);

  fetch_stage #(.XLEN(64), .RESET_PC(64'h1000), .NOP_INSTR(NOP), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .Switch_Branch(sb), .Flush(fl),
    .branch_target(tgt), .stall(st), .imem_addr(addr), .imem_rdata(rdata),
    .if_id_pc(ifpc), .if_id_instr(ifinstr), .if_id_valid(ifv),
    .misalign_err(mis), .redirect_cnt(rc), .bubble_cnt(bc)
  );

  fetch_stage #(.XLEN(64), .RESET_PC(64'h1000), .NOP_INSTR(NOP), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .Switch_Branch(sb), .Flush(fl),
    .branch_target(tgt), .stall(st), .imem_addr(addr_s), .imem_rdata(rdata_s),
    .if_id_pc(ifpc_s), .if_id_instr(ifinstr_s), .if_id_valid(ifv_s),
    .misalign_err(mis_s), .redirect_cnt(rc_s), .bubble_cnt(bc_s)
  );

  typedef struct {
    string       name;
    logic [63:0] addr;
    logic        v;
    logic [63:0] pc;
    logic [31:0] rc;
    logic [31:0] bc;
    logic        mis;
  } exp_t;

  exp_t q[$];

  function automatic logic [3:0] sat4(input logic [31:0] v);
    return (v > 32'd15) ? 4'd15 : v[3:0];
  endfunction

  task automatic chk(input string nm, input string fld,
                     input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge
  task automatic step(input string nm, input logic rs, input logic b,
                      input logic f, input logic s, input logic [63:0] t,
                      input logic [63:0] e_addr, input logic e_v,
                      input logic [63:0] e_pc, input logic [31:0] e_rc,
                      input logic [31:0] e_bc, input logic e_mis);
    exp_t e;
    @(negedge clk);
    #1;
    reset = rs; sb = b; fl = f; st = s; tgt = t;
    e.name = nm; e.addr = e_addr; e.v = e_v; e.pc = e_pc;
    e.rc = e_rc; e.bc = e_bc; e.mis = e_mis;
    q.push_back(e);
  endtask

  // Monitor: outputs are stable between edges, so compare on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.name, "imem_addr", addr, e.addr);
        chk(e.name, "if_id_valid", {63'd0, ifv}, {63'd0, e.v});
        chk(e.name, "if_id_pc", ifpc, e.pc);
        chk(e.name, "if_id_instr", {32'd0, ifinstr},
            {32'd0, (e.v ? memf(e.pc) : NOP)});
        chk(e.name, "redirect_cnt", {32'd0, rc}, {32'd0, e.rc});
        chk(e.name, "bubble_cnt", {32'd0, bc}, {32'd0, e.bc});
        chk(e.name, "misalign_err", {63'd0, mis}, {63'd0, e.mis});
        chk(e.name, "sat_redirect_cnt", {60'd0, rc_s}, {60'd0, sat4(e.rc)});
        chk(e.name, "sat_bubble_cnt", {60'd0, bc_s}, {60'd0, sat4(e.bc)});
      end
    end
  end

  initial begin
    int budget;
    // reset held 3 cycles
    for (int i = 0; i < 3; i++)
      step("reset", 1, 0, 0, 0, 0, 64'h1000, 0, 64'h0, 0, 0, 0);
    // release: pc walks 0x1000 -> 0x1010
    step("adv0", 0, 0, 0, 0, 0, 64'h1004, 1, 64'h1000, 0, 0, 0);
    step("adv1", 0, 0, 0, 0, 0, 64'h1008, 1, 64'h1004, 0, 0, 0);
    step("adv2", 0, 0, 0, 0, 0, 64'h100C, 1, 64'h1008, 0, 0, 0);
    step("adv3", 0, 0, 0, 0, 0, 64'h1010, 1, 64'h100C, 0, 0, 0);
    // taken branch with flush at pc 0x1010
    step("branch", 0, 1, 1, 0, 64'h2000, 64'h2000, 0, 64'h100C, 1, 1, 0);
    step("br_tgt", 0, 0, 0, 0, 0, 64'h2004, 1, 64'h2000, 1, 1, 0);
    // stall together with redirect: redirect wins
    step("stall_br", 0, 1, 0, 1, 64'h3000, 64'h3000, 0, 64'h2000, 2, 2, 0);
    step("sb_tgt", 0, 0, 0, 0, 0, 64'h3004, 1, 64'h3000, 2, 2, 0);
    step("sb_adv", 0, 0, 0, 0, 0, 64'h3008, 1, 64'h3004, 2, 2, 0);
    // stall alone, 4 cycles
    for (int i = 0; i < 4; i++)
      step("stall", 0, 0, 0, 1, 64'hDEAD, 64'h3008, 1, 64'h3004, 2, 2, 0);
    step("post_stall", 0, 0, 0, 0, 0, 64'h300C, 1, 64'h3008, 2, 2, 0);
    // move to pc 0x40, then flush-only
    step("to_40", 0, 1, 0, 0, 64'h40, 64'h40, 0, 64'h3008, 3, 3, 0);
    step("flush", 0, 0, 1, 0, 64'h9990, 64'h40, 0, 64'h3008, 3, 4, 0);
    step("replay", 0, 0, 0, 0, 0, 64'h44, 1, 64'h40, 3, 4, 0);
    // misaligned target: aligned down, sticky flag
    step("misalign", 0, 1, 0, 0, 64'h2002, 64'h2000, 0, 64'h40, 4, 5, 1);
    for (int i = 1; i <= 10; i++)
      step("mis_sticky", 0, 0, 0, 0, 0, 64'h2000 + 64'(4 * i), 1,
           64'h2000 + 64'(4 * (i - 1)), 4, 5, 1);
    // wrap from 2^64-4 to 0
    step("to_top", 0, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC,
         0, 64'h2024, 5, 6, 1);
    step("wrap", 0, 0, 0, 0, 0, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 5, 6, 1);
    step("post_wrap", 0, 0, 0, 0, 0, 64'h4, 1, 64'h0, 5, 6, 1);
    // reset during a redirect overrides it
    step("reset_br", 1, 1, 0, 0, 64'h5000, 64'h1000, 0, 64'h0, 0, 0, 0);
    // 20 back-to-back redirects: last target wins, 4-bit counters stop at 15
    for (int i = 0; i < 20; i++)
      step("burst", 0, 1, 0, 0, 64'h100 + 64'(16 * i), 64'h100 + 64'(16 * i), 0,
           64'h0, 32'(i + 1), 32'(i + 1), 0);
    step("burst_end", 0, 0, 0, 0, 0, 64'h234, 1, 64'h230, 20, 20, 0);

    budget = 20;
    while (q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    @(posedge clk);
    if (q.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
